// File: rtl/trigger_dbg_pkg.sv
// Shared definitions for the trigger debug blocks: watchdog state encoding,
// event counter width and the default timestamp width.
package trigger_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUSPECT,
    REPORT,
    HOLD
  } wd_state_t;

  localparam int unsigned EVENT_CNT_W  = 16;
  localparam int unsigned TS_W_DEFAULT = 32;

  function automatic logic [EVENT_CNT_W-1:0] sat_inc(input logic [EVENT_CNT_W-1:0] v);
    return (v == '1) ? v : v + EVENT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/trigger_deadlock_watchdog_if.sv
// Report channel from the deadlock watchdog to the status/AXI-Lite side:
// valid/ready handshake carrying the stalled-channel mask and start timestamp.
interface trigger_deadlock_watchdog_if #(
  parameter int unsigned NUM_AXIS = 8,
  parameter int unsigned TS_W     = 32
);

  logic                report_valid;
  logic                report_ready;
  logic [NUM_AXIS-1:0] report_mask;
  logic [TS_W-1:0]     report_start_ts;

  modport master (
    output report_valid,
    output report_mask,
    output report_start_ts,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_mask,
    input  report_start_ts,
    output report_ready
  );

endinterface

// File: rtl/trigger_dbg_timestamp.sv
// Free-running cycle timestamp shared by the trigger debug blocks; wraps
// silently to zero.
module trigger_dbg_timestamp #(
  parameter int unsigned TS_W = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [TS_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count + TS_W'(1);
    end
  end

endmodule

// File: rtl/trigger_deadlock_watchdog.sv
// Qualifies the deadlock monitor's block flag over THRESHOLD consecutive
// cycles, latches the stalled channels and start time, and reports each event once.
module trigger_deadlock_watchdog
  import trigger_dbg_pkg::*;
#(
  parameter int unsigned NUM_AXIS  = 8,
  parameter int unsigned THRESHOLD = 1024,
  parameter int unsigned TS_W      = TS_W_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   block,
  input  logic [NUM_AXIS-1:0]    axis_block_sigs,
  input  logic                   clear,
  output logic                   deadlock,
  output logic                   suspect,
  output logic [EVENT_CNT_W-1:0] event_count,
  trigger_deadlock_watchdog_if.master report
);

  localparam int unsigned      RUN_W    = $clog2(THRESHOLD + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(THRESHOLD - 1);

  wd_state_t           state;
  logic [RUN_W-1:0]    run;
  logic [NUM_AXIS-1:0] mask_d;
  logic [NUM_AXIS-1:0] acc;
  logic [TS_W-1:0]     ts_now;

  trigger_dbg_timestamp #(
    .TS_W(TS_W)
  ) u_ts (
    .clock  (clock),
    .reset_n(reset_n),
    .count  (ts_now)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      run                    <= '0;
      mask_d                 <= '0;
      acc                    <= '0;
      deadlock               <= 1'b0;
      suspect                <= 1'b0;
      event_count            <= '0;
      report.report_valid    <= 1'b0;
      report.report_mask     <= '0;
      report.report_start_ts <= '0;
    end else begin
      // The monitor's block flag is one cycle late; mask_d re-aligns the raw stalls to it.
      mask_d <= axis_block_sigs;
      unique case (state)
        IDLE: begin
          if (block) begin
            state                  <= SUSPECT;
            run                    <= RUN_W'(1);
            acc                    <= mask_d;
            report.report_start_ts <= ts_now;
            suspect                <= 1'b1;
          end
        end
        SUSPECT: begin
          if (!block) begin
            state   <= IDLE;
            run     <= '0;
            acc     <= '0;
            suspect <= 1'b0;
          end else if (run == RUN_LAST) begin
            state               <= REPORT;
            acc                 <= acc | mask_d;
            report.report_mask  <= acc | mask_d;
            report.report_valid <= 1'b1;
            deadlock            <= 1'b1;
            suspect             <= 1'b0;
            event_count         <= sat_inc(event_count);
          end else begin
            run <= run + RUN_W'(1);
            acc <= acc | mask_d;
          end
        end
        REPORT: begin
          acc <= acc | mask_d;
          // A simultaneous handshake still counts as accepted, but clear decides the next state.
          if (clear) begin
            state               <= IDLE;
            run                 <= '0;
            acc                 <= '0;
            report.report_valid <= 1'b0;
            deadlock            <= 1'b0;
          end else if (report.report_ready) begin
            state               <= HOLD;
            report.report_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (clear) begin
            state    <= IDLE;
            run      <= '0;
            acc      <= '0;
            deadlock <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_deadlock_watchdog.sv
// Bench for trigger_deadlock_watchdog: directed scenarios plus random traffic,
// checked against a streak-counting reference model.
module tb_trigger_deadlock_watchdog;

  localparam int unsigned NUM_AXIS  = 8;
  localparam int unsigned THRESHOLD = 8;
  localparam int unsigned TS_W      = 32;

  logic                clock;
  logic                reset_n;
  logic                block;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic                clear;
  logic                deadlock;
  logic                suspect;
  logic [15:0]         event_count;

  int unsigned n_checks;
  int unsigned n_fail;

  trigger_deadlock_watchdog_if #(.NUM_AXIS(NUM_AXIS), .TS_W(TS_W)) rep ();

  trigger_deadlock_watchdog #(
    .NUM_AXIS (NUM_AXIS),
    .THRESHOLD(THRESHOLD),
    .TS_W     (TS_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .block          (block),
    .axis_block_sigs(axis_block_sigs),
    .clear          (clear),
    .deadlock       (deadlock),
    .suspect        (suspect),
    .event_count    (event_count),
    .report         (rep)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: counts the current streak of block samples; an event
  // latches when the streak reaches THRESHOLD and stays latched until clear.
  logic [TS_W-1:0]     m_ts, n_ts;
  logic [NUM_AXIS-1:0] m_mask_d;
  int unsigned         m_streak, n_streak;
  logic [NUM_AXIS-1:0] m_acc, n_acc, m_rep_mask, n_rep_mask;
  logic                m_latched, n_latched, m_pending, n_pending;
  logic [TS_W-1:0]     m_start, n_start;
  logic [15:0]         m_events, n_events;
  int unsigned         ts_load_seq, ts_seen;
  logic [TS_W-1:0]     ts_load_val;

  always_comb begin
    n_ts       = (ts_load_seq != ts_seen) ? ts_load_val : m_ts;
    n_streak   = m_streak;
    n_acc      = m_acc;
    n_latched  = m_latched;
    n_pending  = m_pending;
    n_rep_mask = m_rep_mask;
    n_start    = m_start;
    n_events   = m_events;
    if (m_latched) begin
      if (m_pending && rep.report_ready) n_pending = 1'b0;
      if (clear) begin
        n_latched = 1'b0;
        n_pending = 1'b0;
        n_streak  = 0;
        n_acc     = '0;
      end
    end else if (block) begin
      if (m_streak == 0) begin
        n_start = n_ts;
        n_acc   = m_mask_d;
      end else begin
        n_acc = m_acc | m_mask_d;
      end
      n_streak = m_streak + 1;
      if (n_streak == THRESHOLD) begin
        n_latched  = 1'b1;
        n_pending  = 1'b1;
        n_rep_mask = n_acc;
        if (m_events != 16'hFFFF) n_events = m_events + 16'd1;
      end
    end else begin
      n_streak = 0;
      n_acc    = '0;
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ts       <= '0;
      m_mask_d   <= '0;
      m_streak   <= 0;
      m_acc      <= '0;
      m_latched  <= 1'b0;
      m_pending  <= 1'b0;
      m_rep_mask <= '0;
      m_start    <= '0;
      m_events   <= '0;
    end else begin
      m_ts       <= n_ts + 32'd1;
      m_mask_d   <= axis_block_sigs;
      m_streak   <= n_streak;
      m_acc      <= n_acc;
      m_latched  <= n_latched;
      m_pending  <= n_pending;
      m_rep_mask <= n_rep_mask;
      m_start    <= n_start;
      m_events   <= n_events;
      ts_seen    <= ts_load_seq;
    end
  end

  function automatic logic [58:0] obs();
    return {deadlock, suspect, rep.report_valid, rep.report_mask, rep.report_start_ts, event_count};
  endfunction

  function automatic logic [58:0] mdl();
    return {m_latched, (!m_latched && m_streak != 0), m_pending, m_rep_mask, m_start, m_events};
  endfunction

  // Apply inputs after a falling edge, let one rising edge pass, return on the next falling edge.
  task automatic tick(input logic b, input logic [NUM_AXIS-1:0] s, input logic clr, input logic rdy);
    block            = b;
    axis_block_sigs  = s;
    clear            = clr;
    rep.report_ready = rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    block = 1'b1;
    axis_block_sigs = 8'hFF;
    clear = 1'b0;
    rep.report_ready = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (obs() !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", obs());
    end
    reset_n = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (obs() !== 59'd0 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=0 model=%h", obs(), mdl());
    end
  endtask

  task automatic test_short_stall();
    int unsigned sus = 0;
    int unsigned bad = 0;
    tick(1'b0, 8'h04, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick(i <= 7, 8'h04, 1'b0, 1'b0);
      if (suspect) sus++;
      if (deadlock || rep.report_valid) bad++;
      n_checks++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL short_stall_cycle%0d got=%h want=%h", i, obs(), mdl());
      end
    end
    n_checks++;
    if (sus != 7 || bad != 0 || event_count !== 16'd0) begin
      n_fail++;
      $display("FAIL short_stall_summary got suspect=%0d dl/valid=%0d events=%0d want 7/0/0", sus, bad, event_count);
    end
  endtask

  task automatic test_deadlock_ready();
    logic [TS_W-1:0] ts_first;
    int unsigned     beats = 0;
    tick(1'b0, 8'h01, 1'b0, 1'b1);
    ts_first = m_ts;
    for (int i = 1; i <= 23; i++) begin
      tick(i <= 20, (i < 3) ? 8'h01 : 8'h10, 1'b0, 1'b1);
      if (rep.report_valid) beats++;
      n_checks++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL deadlock_ready_cycle%0d got=%h want=%h", i, obs(), mdl());
      end
      if (i == 7) begin
        n_checks++;
        if (deadlock !== 1'b0) begin
          n_fail++;
          $display("FAIL deadlock_early got=%b want=0", deadlock);
        end
      end
      if (i == 8) begin
        n_checks++;
        if ({deadlock, rep.report_valid, rep.report_mask, rep.report_start_ts} !== {1'b1, 1'b1, 8'h11, ts_first}) begin
          n_fail++;
          $display("FAIL deadlock_report got dl=%b v=%b mask=%h ts=%h want 1/1/11/%h",
                   deadlock, rep.report_valid, rep.report_mask, rep.report_start_ts, ts_first);
        end
      end
    end
    n_checks++;
    if (deadlock !== 1'b1 || beats != 1 || event_count !== 16'd1) begin
      n_fail++;
      $display("FAIL deadlock_after got dl=%b beats=%0d events=%0d want 1/1/1", deadlock, beats, event_count);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (deadlock !== 1'b0 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL clear_hold got=%h want=%h", obs(), mdl());
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_AXIS-1:0] pm;
    logic [TS_W-1:0]     pt;
    tick(1'b0, NUM_AXIS'($urandom), 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) tick(1'b1, NUM_AXIS'($urandom), 1'b0, 1'b0);
    pm = m_rep_mask;
    pt = m_start;
    n_checks++;
    if (obs() !== mdl() || rep.report_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_entry got=%h want=%h", obs(), mdl());
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, NUM_AXIS'($urandom), 1'b0, 1'b0);
      n_checks++;
      if ({rep.report_valid, rep.report_mask, rep.report_start_ts} !== {1'b1, pm, pt} || obs() !== mdl()) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%b mask=%h ts=%h want 1/%h/%h", i, rep.report_valid,
                 rep.report_mask, rep.report_start_ts, pm, pt);
      end
    end
    tick(1'b1, NUM_AXIS'($urandom), 1'b0, 1'b1);
    n_checks++;
    if (rep.report_valid !== 1'b0 || deadlock !== 1'b1 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL bp_accept got=%h want=%h", obs(), mdl());
    end
    repeat (2) tick(1'b1, NUM_AXIS'($urandom), 1'b0, 1'b1);
    n_checks++;
    if ({deadlock, suspect, rep.report_valid} !== 3'b100 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL bp_hold_state got=%h want=%h", obs(), mdl());
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_clear_in_report();
    logic [15:0] e0;
    e0 = m_events;
    tick(1'b0, 8'h02, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) tick(1'b1, 8'h02, 1'b0, 1'b0);
    n_checks++;
    if (rep.report_valid !== 1'b1 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL clr_entry got=%h want=%h", obs(), mdl());
    end
    tick(1'b1, 8'h02, 1'b1, 1'b0);
    n_checks++;
    if ({deadlock, suspect, rep.report_valid} !== 3'b000 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL clr_drop got=%h want=%h", obs(), mdl());
    end
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 8'h02, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== mdl() || (j == 1 && suspect !== 1'b1) || (j == 7 && deadlock !== 1'b0)
          || (j == 8 && deadlock !== 1'b1)) begin
        n_fail++;
        $display("FAIL clr_restart%0d got=%h want=%h", j, obs(), mdl());
      end
    end
    n_checks++;
    if (event_count !== e0 + 16'd2) begin
      n_fail++;
      $display("FAIL clr_events got=%0d want=%0d", event_count, e0 + 16'd2);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    tick(1'b0, 8'h08, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) tick(1'b1, 8'h08, 1'b0, 1'b0);
    n_checks++;
    if (suspect !== 1'b1 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL arst_pre got=%h want=%h", obs(), mdl());
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 59'd0) begin
      n_fail++;
      $display("FAIL arst_immediate got=%h want=0", obs());
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 8'h08, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== mdl() || (j == 1 && suspect !== 1'b1) || (j == 7 && deadlock !== 1'b0)
          || (j == 8 && (deadlock !== 1'b1 || event_count !== 16'd1))) begin
        n_fail++;
        $display("FAIL arst_restart%0d got=%h want=%h", j, obs(), mdl());
      end
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_ts_wrap();
    force dut.u_ts.count = 32'hFFFF_FFFE;
    ts_load_val = 32'hFFFF_FFFE;
    ts_load_seq++;
    #1 release dut.u_ts.count;
    tick(1'b0, 8'h80, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) tick(1'b1, 8'h80, 1'b0, 1'b0);
    n_checks++;
    if (rep.report_start_ts !== 32'hFFFF_FFFF || rep.report_mask !== 8'h80 || obs() !== mdl()) begin
      n_fail++;
      $display("FAIL ts_wrap got ts=%h mask=%h want ffffffff/80 model=%h", rep.report_start_ts,
               rep.report_mask, mdl());
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 15) != 0, NUM_AXIS'($urandom), $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)));
      n_checks++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, obs(), mdl());
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    ts_load_seq = 0;
    ts_load_val = '0;
    test_reset();
    test_short_stall();
    test_deadlock_ready();
    test_backpressure();
    test_clear_in_report();
    test_async_reset();
    test_ts_wrap();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
